// File: rtl/register_file_if.sv
// Bundle of write-back, read-port and issue-scoreboard signals for register_file.
// The master side belongs to the pipeline; the slave side belongs to the register file.
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [3:0]        opcode;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_dest;
    logic              iss_ready;

    modport master (
        output opcode, wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, iss_valid, iss_dest,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, iss_ready
    );

    modport slave (
        input  opcode, wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, iss_valid, iss_dest,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, iss_ready
    );
endinterface

// File: rtl/register_file.sv
// General-purpose register file: two bypassed combinational read ports, opcode-gated
// write-back and a per-register busy scoreboard for RAW/WAW stalls at issue.
module register_file #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 16,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int ZERO_REG = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    register_file_if.slave       bus
);

    logic [DATA_W-1:0] regs_r [NREGS];
    logic [NREGS-1:0]  busy_r;
    logic [NREGS-1:0]  busy_nxt_s;
    logic              commit_s;
    logic              iss_ready_s;
    logic [DATA_W-1:0] rd_data1_s;
    logic [DATA_W-1:0] rd_data2_s;
    logic              rd_busy1_s;
    logic              rd_busy2_s;

    function automatic logic hardwired(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == {ADDR_W{1'b0}});
    endfunction

    // A write-back matching this address overrides the stored value in the same cycle.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        if (hardwired(a)) begin
            v = {DATA_W{1'b0}};
        end else if (commit_s && (bus.wr_addr == a)) begin
            v = bus.wr_data;
        end else begin
            v = regs_r[a];
        end
        return v;
    endfunction

    function automatic logic busy_port(input logic [ADDR_W-1:0] a);
        return busy_r[a] && !(commit_s && (bus.wr_addr == a));
    endfunction

    // Write-back commits unless the opcode produces no register result.
    always_comb begin
        commit_s = 1'b0;
        if (bus.wr_en) begin
            case (bus.opcode)
                4'b1111, 4'b1000, 4'b1010: commit_s = 1'b0;
                default:                   commit_s = 1'b1;
            endcase
        end else begin
            commit_s = 1'b0;
        end
    end

    // Read ports and issue handshake, all combinational.
    always_comb begin
        rd_data1_s  = read_port(bus.rd_addr1);
        rd_data2_s  = read_port(bus.rd_addr2);
        rd_busy1_s  = busy_port(bus.rd_addr1);
        rd_busy2_s  = busy_port(bus.rd_addr2);
        iss_ready_s = !busy_port(bus.iss_dest);
    end

    // Scoreboard next state: clear on commit, then set on accepted issue so a new producer wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (commit_s) begin
            busy_nxt_s[bus.wr_addr] = 1'b0;
        end else begin
            busy_nxt_s[bus.wr_addr] = busy_r[bus.wr_addr];
        end
        if (bus.iss_valid && iss_ready_s && !hardwired(bus.iss_dest)) begin
            busy_nxt_s[bus.iss_dest] = 1'b1;
        end else begin
            busy_nxt_s[bus.iss_dest] = busy_nxt_s[bus.iss_dest];
        end
    end

    // Register array and scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            busy_r <= {NREGS{1'b0}};
        end else begin
            if (commit_s && !hardwired(bus.wr_addr)) begin
                regs_r[bus.wr_addr] <= bus.wr_data;
            end
            busy_r <= busy_nxt_s;
        end
    end

    assign bus.rd_data1  = rd_data1_s;
    assign bus.rd_data2  = rd_data2_s;
    assign bus.rd_busy1  = rd_busy1_s;
    assign bus.rd_busy2  = rd_busy2_s;
    assign bus.iss_ready = iss_ready_s;

endmodule
